// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID stage read side and
// the writeback/register-file block.
// master: drives the writeback request and read indices, consumes read data.
// slave : the register file; consumes the request and drives read data, WB_DATA,
//         WB_VALID and the committed-write counter.
interface wb_regfile_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             RegWrite_WB;
   logic             MemtoReg_WB;
   logic [XLEN-1:0]  DATA_MEMORY_WB;
   logic [XLEN-1:0]  ALU_OUT_WB;
   logic [4:0]       RD_WB;
   logic [4:0]       RS1_ID;
   logic [4:0]       RS2_ID;
   logic [4:0]       DBG_ADDR;
   logic [XLEN-1:0]  REG_DATA_1_ID;
   logic [XLEN-1:0]  REG_DATA_2_ID;
   logic [XLEN-1:0]  DBG_DATA;
   logic [XLEN-1:0]  WB_DATA;
   logic             WB_VALID;
   logic [CNT_W-1:0] WB_COUNT;

   modport master (
      output RegWrite_WB, MemtoReg_WB, DATA_MEMORY_WB, ALU_OUT_WB, RD_WB,
             RS1_ID, RS2_ID, DBG_ADDR,
      input  REG_DATA_1_ID, REG_DATA_2_ID, DBG_DATA, WB_DATA, WB_VALID, WB_COUNT
   );

   modport slave (
      input  RegWrite_WB, MemtoReg_WB, DATA_MEMORY_WB, ALU_OUT_WB, RD_WB,
             RS1_ID, RS2_ID, DBG_ADDR,
      output REG_DATA_1_ID, REG_DATA_2_ID, DBG_DATA, WB_DATA, WB_VALID, WB_COUNT
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback select + 32x32 integer register file with same-cycle write bypass.
// Latency: reads combinational; a write commits on the edge ending its WB cycle.
// Backpressure: none; a write is accepted every cycle it is presented.
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   reset - synchronous, active-high; clears x1..x31 and the write counter
//   bus   - wb_regfile_if.slave: writeback request (RegWrite/MemtoReg/data/RD),
//           read indices RS1/RS2/DBG, read data, WB_DATA/WB_VALID, WB_COUNT
// XLEN/CNT_W must match the parameters of the connected interface.
module wb_regfile #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input logic         clk,
   input logic         reset,
   wb_regfile_if.slave bus
);

   // x0 is hardwired to zero, so only x1..x31 get storage.
   logic [XLEN-1:0]  regs [1:31];
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  wb_data;
   logic             wb_valid;

   assign wb_data  = bus.MemtoReg_WB ? bus.DATA_MEMORY_WB : bus.ALU_OUT_WB;
   // Gating with reset makes reset win over a pending write and also turns
   // off the read bypass while reset is held.
   assign wb_valid = bus.RegWrite_WB && (bus.RD_WB != 5'd0) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= '0;
         end
         count <= '0;
      end else if (wb_valid) begin
         regs[bus.RD_WB] <= wb_data;
         count           <= count + CNT_W'(1);
      end
   end

   // ID read ports forward the value being written this cycle so the
   // pipeline never needs a WB->ID stall.
   assign bus.REG_DATA_1_ID = (bus.RS1_ID == 5'd0)                  ? '0      :
                              (wb_valid && bus.RD_WB == bus.RS1_ID) ? wb_data :
                                                                      regs[bus.RS1_ID];
   assign bus.REG_DATA_2_ID = (bus.RS2_ID == 5'd0)                  ? '0      :
                              (wb_valid && bus.RD_WB == bus.RS2_ID) ? wb_data :
                                                                      regs[bus.RS2_ID];

   // Debug port shows raw array contents, deliberately without bypass.
   assign bus.DBG_DATA = (bus.DBG_ADDR == 5'd0) ? '0 : regs[bus.DBG_ADDR];

   assign bus.WB_DATA  = wb_data;
   assign bus.WB_VALID = wb_valid;
   assign bus.WB_COUNT = count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. The driver applies one vector per cycle and
// queues the hand-computed expected outputs for that cycle; a monitor pops the
// queue on the falling edge and compares against the DUT outputs.
// The DUT counter is built 4 bits wide so the wrap case is reachable.
module tb_wb_regfile;
   localparam int XLEN  = 32;
   localparam int CNT_W = 4;

   // field-select bits for an expectation
   localparam logic [5:0] M_RD1 = 6'b000001;
   localparam logic [5:0] M_RD2 = 6'b000010;
   localparam logic [5:0] M_DBG = 6'b000100;
   localparam logic [5:0] M_WB  = 6'b001000;
   localparam logic [5:0] M_VLD = 6'b010000;
   localparam logic [5:0] M_CNT = 6'b100000;
   localparam logic [5:0] M_ALL = 6'b111111;

   typedef struct {
      string       nm;
      logic [5:0]  msk;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] dbg;
      logic [31:0] wb;
      logic        vld;
      logic [3:0]  cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   wb_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   wb_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, expv);
      end
   endtask

   // Monitor: every cycle has combinational outputs to observe; one queued
   // expectation is consumed per cycle, away from the rising edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.msk[0]) chk(e.nm, "rd1", bus.REG_DATA_1_ID, e.rd1);
         if (e.msk[1]) chk(e.nm, "rd2", bus.REG_DATA_2_ID, e.rd2);
         if (e.msk[2]) chk(e.nm, "dbg", bus.DBG_DATA, e.dbg);
         if (e.msk[3]) chk(e.nm, "wb_data", bus.WB_DATA, e.wb);
         if (e.msk[4]) chk(e.nm, "wb_valid", {31'd0, bus.WB_VALID}, {31'd0, e.vld});
         if (e.msk[5]) chk(e.nm, "wb_count", {28'd0, bus.WB_COUNT}, {28'd0, e.cnt});
      end
   end

   // Apply one cycle of stimulus and queue what the outputs must be in it.
   task automatic step(input logic rst, input logic rw, input logic mtr,
                       input logic [31:0] dm, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] dbg,
                       input string nm, input logic [5:0] msk,
                       input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                       input logic [31:0] e_dbg, input logic [31:0] e_wb,
                       input logic e_vld, input logic [3:0] e_cnt);
      exp_t e;
      @(posedge clk);
      #1;
      reset              = rst;
      bus.RegWrite_WB    = rw;
      bus.MemtoReg_WB    = mtr;
      bus.DATA_MEMORY_WB = dm;
      bus.ALU_OUT_WB     = alu;
      bus.RD_WB          = rd;
      bus.RS1_ID         = rs1;
      bus.RS2_ID         = rs2;
      bus.DBG_ADDR       = dbg;
      e.nm  = nm;  e.msk = msk;
      e.rd1 = e_rd1; e.rd2 = e_rd2; e.dbg = e_dbg; e.wb = e_wb;
      e.vld = e_vld; e.cnt = e_cnt;
      exp_q.push_back(e);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      bus.RegWrite_WB = 1'b0; bus.MemtoReg_WB = 1'b0;
      bus.DATA_MEMORY_WB = '0; bus.ALU_OUT_WB = '0; bus.RD_WB = '0;
      bus.RS1_ID = '0; bus.RS2_ID = '0; bus.DBG_ADDR = '0;

      //   rst rw mtr dm            alu           rd  rs1 rs2 dbg  name       mask          rd1           rd2           dbg           wb            vld cnt
      // Reset held two cycles with a write pending; array is unknown until the first edge.
      step(1, 1, 0, 32'h0,        32'hDEADBEEF, 5,  5,  5,  5,  "rst0",   M_WB | M_VLD, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 0, 4'd0);
      step(1, 1, 0, 32'h0,        32'hDEADBEEF, 5,  5,  5,  5,  "rst1",   M_ALL,        32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 0, 4'd0);
      step(0, 0, 0, 32'h0,        32'h0,        0,  5,  5,  5,  "rst_x5", M_ALL,        32'h0,        32'h0,        32'h0,        32'h0,        0, 4'd0);
      // ALU write to x7, then load write to x8 (the other mux input holds a decoy).
      step(0, 1, 0, 32'hFFFF0000, 32'h12345678, 7,  7,  8,  7,  "wr_x7",  M_ALL,        32'h12345678, 32'h0,        32'h0,        32'h12345678, 1, 4'd0);
      step(0, 1, 1, 32'hCAFEF00D, 32'h11111111, 8,  7,  8,  7,  "ld_x8",  M_ALL,        32'h12345678, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 1, 4'd1);
      step(0, 0, 0, 32'h0,        32'h0,        0,  7,  8,  8,  "rb_x8",  M_ALL,        32'h12345678, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        0, 4'd2);
      // Same-cycle bypass on both ports; debug still shows the old value.
      step(0, 1, 0, 32'h0,        32'hA5A5A5A5, 9,  9,  9,  9,  "byp_x9", M_ALL,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        32'hA5A5A5A5, 1, 4'd2);
      step(0, 0, 0, 32'h0,        32'h0,        0,  9,  9,  9,  "rb_x9",  M_ALL,        32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0,        0, 4'd3);
      // Write to x0 is dropped and not counted.
      step(0, 1, 0, 32'h0,        32'hFFFFFFFF, 0,  0,  9,  0,  "wr_x0",  M_ALL,        32'h0,        32'hA5A5A5A5, 32'h0,        32'hFFFFFFFF, 0, 4'd3);
      // Disabled write: no bypass, no commit, WB_DATA still driven.
      step(0, 0, 0, 32'h0,        32'h55,       3,  3,  0,  3,  "dis_x3", M_ALL,        32'h0,        32'h0,        32'h0,        32'h55,       0, 4'd3);
      step(0, 0, 0, 32'h0,        32'h0,        0,  3,  0,  3,  "rb_x3",  M_ALL,        32'h0,        32'h0,        32'h0,        32'h0,        0, 4'd3);
      // Back-to-back writes to x10: last wins, each counts once.
      step(0, 1, 0, 32'h0,        32'h1,        10, 10, 0,  10, "b2b_1",  M_ALL,        32'h1,        32'h0,        32'h0,        32'h1,        1, 4'd3);
      step(0, 1, 0, 32'h0,        32'h2,        10, 10, 0,  10, "b2b_2",  M_ALL,        32'h2,        32'h0,        32'h1,        32'h2,        1, 4'd4);
      step(0, 0, 0, 32'h0,        32'h0,        0,  10, 0,  10, "rb_x10", M_ALL,        32'h2,        32'h0,        32'h2,        32'h0,        0, 4'd5);
      // Reset again with a write pending to x12; x7 must come back cleared.
      step(1, 1, 0, 32'h0,        32'h77,       12, 12, 7,  7,  "rst2",   M_RD1 | M_WB | M_VLD | M_CNT | M_DBG, 32'h0, 32'h0, 32'h12345678, 32'h77, 0, 4'd5);
      step(0, 0, 0, 32'h0,        32'h0,        0,  12, 7,  7,  "rst2_q", M_ALL,        32'h0,        32'h0,        32'h0,        32'h0,        0, 4'd0);

      // 17 writes to x11 with values 1..17: the 4-bit counter wraps to 1.
      for (int i = 0; i < 17; i++) begin
         step(0, 1, 0, 32'h0, 32'(i + 1), 11, 11, 0, 11, "wrap_wr", M_ALL,
              32'(i + 1), 32'h0, 32'(i), 32'(i + 1), 1, 4'(i));
      end
      step(0, 0, 0, 32'h0,        32'h0,        0,  11, 0,  11, "wrap_q", M_ALL,        32'h11,       32'h0,        32'h11,       32'h0,        0, 4'd1);
      // Reset mid-stream with a write to x13 pending: write lost, count cleared.
      step(1, 1, 0, 32'h0,        32'h99,       13, 13, 13, 11, "rst3",   M_RD1 | M_RD2 | M_DBG | M_WB | M_VLD | M_CNT, 32'h0, 32'h0, 32'h11, 32'h99, 0, 4'd1);
      step(0, 0, 0, 32'h0,        32'h0,        0,  13, 11, 13, "rst3_q", M_ALL,        32'h0,        32'h0,        32'h0,        32'h0,        0, 4'd0);

      // Let the monitor drain the queue, with a bound.
      for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
      @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage RISC-V pipeline. It consumes the outputs of the MEM/WB pipeline register, selects the writeback value (load data or ALU result), and commits it to the 32×32 integer register file. It serves the ID stage with two combinational read ports that include same-cycle write bypass, exports the writeback value for EX-stage forwarding, and keeps a committed-write counter for debug.

## Interface
Parameters:
- XLEN, 32, data width of registers and writeback path
- CNT_W, 32, width of committed-write counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- RegWrite_WB  input  1  writeback enable from MEM/WB register
- MemtoReg_WB  input  1  1 selects DATA_MEMORY_WB, 0 selects ALU_OUT_WB
- DATA_MEMORY_WB  input  XLEN  load data
- ALU_OUT_WB  input  XLEN  ALU result
- RD_WB  input  5  destination register index
- RS1_ID  input  5  read port 1 index
- RS2_ID  input  5  read port 2 index
- DBG_ADDR  input  5  debug read index (no bypass)
- REG_DATA_1_ID  output  XLEN  read port 1 data
- REG_DATA_2_ID  output  XLEN  read port 2 data
- DBG_DATA  output  XLEN  debug read data, raw array contents
- WB_DATA  output  XLEN  selected writeback value, to forwarding mux in EX
- WB_VALID  output  1  high when a real register write occurs this cycle
- WB_COUNT  output  CNT_W  number of committed writes since reset

## Operation
- WB_DATA = MemtoReg_WB ? DATA_MEMORY_WB : ALU_OUT_WB; combinational, independent of reset.
- WB_VALID = RegWrite_WB & (RD_WB != 0) & ~reset; combinational.
- Register array x1..x31; x0 not stored, always reads 0; writes to x0 are dropped.
- Rising edge, reset=1: x1..x31 ← 0, WB_COUNT ← 0; any pending write is discarded (reset wins).
- Rising edge, reset=0, WB_VALID=1: x[RD_WB] ← WB_DATA; WB_COUNT ← WB_COUNT+1, modulo 2^CNT_W (wraps to 0 from all-ones).
- Read port n (RSn_ID): if index == 0 → 0; else if WB_VALID and RD_WB == index → WB_DATA (bypass); else x[index].
- Both read ports bypass independently; RS1_ID == RS2_ID == RD_WB returns WB_DATA on both.
- DBG_DATA = (DBG_ADDR == 0) ? 0 : x[DBG_ADDR]; no bypass.
- RegWrite_WB=0: no state change regardless of other inputs; WB_DATA still driven.

## Timing
- Write latency: value is committed at the rising edge ending the WB cycle; visible on DBG_DATA from the next cycle.
- Read ports see the value in the same cycle via bypass, so ID never needs a WB→ID stall.
- Reads are combinational; no read latency.
- Reset values after first reset edge: all registers 0, WB_COUNT 0, DBG_DATA 0, REG_DATA_1_ID/REG_DATA_2_ID 0 (bypass disabled while reset high).
- During reset cycle WB_VALID=0, WB_DATA follows inputs.
- Reset asserted mid-stream: the write presented in that cycle is lost; the counter does not increment.
- Back-to-back writes to the same register: the last one wins; each counts once.

## Test plan
- Reset: assert reset 2 cycles with RegWrite_WB=1, RD_WB=5, ALU_OUT_WB=0xDEADBEEF -> x5 reads 0, WB_COUNT=0, WB_VALID=0 throughout.
- Write/readback: write ALU 0x12345678 to x7 (MemtoReg=0), then load 0xCAFEF00D to x8 (MemtoReg=1) -> DBG x7=0x12345678, x8=0xCAFEF00D, WB_COUNT=2.
- Bypass: RS1_ID=RS2_ID=RD_WB=9, write 0xA5A5A5A5 -> both read ports 0xA5A5A5A5 same cycle while DBG_DATA(x9) still old value 0; next cycle DBG_DATA=0xA5A5A5A5.
- x0: RegWrite_WB=1, RD_WB=0, data 0xFFFFFFFF -> RS1_ID=0 reads 0, WB_VALID=0, WB_COUNT unchanged.
- Disabled write: RegWrite_WB=0, RD_WB=3, data 0x55 -> x3 unchanged, no bypass on RS1_ID=3, WB_DATA=0x55.
- Counter wrap: CNT_W=4, 17 valid writes -> WB_COUNT=1; reset mid-sequence with a write pending -> register unchanged, count 0.
